sonar_frame_sequencer: RTL and testbench

SONAR_FRAME_SEQUENCER -- requirements
Module: sonar_frame_sequencer

---
 rtl/sonar_frame_sequencer.sv | 84 ++++++++
 tb/tb_sonar_frame_sequencer.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/sonar_frame_sequencer.sv
// sonar_frame_sequencer: formats a latched angle/distance reading as an 8-character ASCII frame and
// hands it to a serial transmitter one character at a time, aborting if the transmitter stalls.
module sonar_frame_sequencer #(
  parameter int TIMEOUT_TX = 100_000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        iniciar,
  input  logic [11:0] angulo,
  input  logic [11:0] medida,
  input  logic        medida_valida,
  input  logic        pronto_tx,
  output logic        partida_tx,
  output logic [6:0]  dado_tx,
  output logic        ocupado,
  output logic        fim_frame,
  output logic        erro,
  output logic [3:0]  db_estado
);
  localparam int CW = TIMEOUT_TX > 1 ? $clog2(TIMEOUT_TX) : 1;
  typedef enum logic [3:0] {
    INICIAL = 4'h0, CAPTURA = 4'h1, ENVIA = 4'h2, ESPERA = 4'h3,
    PROXIMO = 4'h4, FIM = 4'h5, ERRO = 4'hF
  } state_t;
  state_t st, nxt;
  logic [2:0] idx;
  logic [CW-1:0] cnt;
  logic [11:0] ang, med;
  logic val;
  logic [6:0] chr;
  function automatic logic [6:0] dig(input logic [3:0] n);
    return n < 4'd10 ? {3'b011, n} : 7'h3F;
  endfunction
  always_comb begin
    nxt = st;
    case (st)
      INICIAL: nxt = iniciar ? CAPTURA : INICIAL;
      CAPTURA: nxt = ENVIA;
      ENVIA:   nxt = ESPERA;
      ESPERA:  nxt = pronto_tx ? PROXIMO : (cnt == CW'(TIMEOUT_TX - 1)) ? ERRO : ESPERA;
      PROXIMO: nxt = idx == 3'd7 ? FIM : ENVIA;
      default: nxt = INICIAL;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st  <= INICIAL;
      idx <= '0;
      cnt <= '0;
      ang <= '0;
      med <= '0;
      val <= 1'b0;
    end else begin
      st <= nxt;
      if (st == CAPTURA) begin
        ang <= angulo;
        med <= medida;
        val <= medida_valida;
        idx <= '0;
      end else if (st == PROXIMO && idx != 3'd7) idx <= idx + 3'd1;
      // counter only runs inside ESPERA, so every entry starts from zero
      cnt <= st == ESPERA ? cnt + CW'(1) : '0;
    end
  end
  always_comb begin
    chr = 7'h00;
    case (idx)
      3'd0: chr = dig(ang[11:8]);
      3'd1: chr = dig(ang[7:4]);
      3'd2: chr = dig(ang[3:0]);
      3'd3: chr = 7'h2C;
      3'd4: chr = val ? dig(med[11:8]) : 7'h2D;
      3'd5: chr = val ? dig(med[7:4]) : 7'h2D;
      3'd6: chr = val ? dig(med[3:0]) : 7'h2D;
      default: chr = 7'h23;
    endcase
  end
  assign partida_tx = st == ENVIA;
  assign dado_tx    = (st == ENVIA || st == ESPERA) ? chr : 7'h00;
  assign ocupado    = st != INICIAL;
  assign fim_frame  = st == FIM;
  assign erro       = st == ERRO;
  assign db_estado  = st;
endmodule

// File: tb/tb_sonar_frame_sequencer.sv
// tb_sonar_frame_sequencer: randomized frames against a character-level reference model, with a
// scoreboard monitor popping expected characters and end events as the DUT emits them.
module tb_sonar_frame_sequencer;
  logic clock = 0, reset = 0, iniciar = 0, medida_valida = 0, pronto_tx = 0;
  logic [11:0] angulo = 0, medida = 0;
  logic partida_tx, ocupado, fim_frame, erro;
  logic [6:0] dado_tx;
  logic [3:0] db_estado;
  int checks = 0, passed = 0;
  logic [6:0] exp_chr[$];
  int exp_evt[$];

  always #5 clock = ~clock;

  sonar_frame_sequencer #(.TIMEOUT_TX(16)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .angulo(angulo), .medida(medida),
    .medida_valida(medida_valida), .pronto_tx(pronto_tx), .partida_tx(partida_tx),
    .dado_tx(dado_tx), .ocupado(ocupado), .fim_frame(fim_frame), .erro(erro),
    .db_estado(db_estado)
  );

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act == req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
  endtask

  function automatic logic [6:0] dg(input logic [3:0] n);
    return n < 4'd10 ? 7'h30 + 7'(n) : 7'h3F;
  endfunction

  // event codes: 1 = fim_frame, 2 = erro
  task automatic expect_frame(input logic [11:0] a, input logic [11:0] m, input logic v,
                              input int nch, input int evt);
    logic [6:0] f[8];
    f = '{dg(a[11:8]), dg(a[7:4]), dg(a[3:0]), 7'h2C,
          v ? dg(m[11:8]) : 7'h2D, v ? dg(m[7:4]) : 7'h2D, v ? dg(m[3:0]) : 7'h2D, 7'h23};
    for (int i = 0; i < nch; i++) exp_chr.push_back(f[i]);
    exp_evt.push_back(evt);
  endtask

  always @(negedge clock) begin
    if (reset) begin
      if (partida_tx) begin
        if (exp_chr.size() == 0) chk("extra_partida", 1, 0);
        else chk("char", dado_tx, exp_chr.pop_front());
      end
      if (fim_frame || erro) begin
        if (exp_evt.size() == 0) chk("extra_end", {erro, fim_frame}, 0);
        else chk("end_event", {erro, fim_frame}, exp_evt.pop_front());
      end
    end
  end

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_partida"}, partida_tx, 0);
    chk({tag, "_dado"}, dado_tx, 0);
    chk({tag, "_ocupado"}, ocupado, 0);
    chk({tag, "_fim"}, fim_frame, 0);
    chk({tag, "_erro"}, erro, 0);
    chk({tag, "_estado"}, db_estado, 0);
  endtask

  // dly < 0 picks a random reply delay; stall_at/rst_at < 0 disables those scenarios
  task automatic run_frame(input logic [11:0] a, input logic [11:0] m, input logic v, input int dly,
                           input int stall_at, input bit tie, input bit ign, input int rst_at);
    int n, j;
    bit stalled = 0;
    expect_frame(a, m, v, stall_at >= 0 ? stall_at + 1 : 8, stall_at >= 0 ? 2 : 1);
    @(posedge clock); #1;
    angulo = a; medida = m; medida_valida = v; iniciar = 1;
    for (int k = 0; k < 8; k++) begin
      n = 0;
      do begin
        @(posedge clock); #1;
        n++;
        if (k == 0) iniciar = 0;
      end while (!partida_tx && n < 40);
      if (!partida_tx) begin
        chk("partida_wait", 0, 1);
        return;
      end
      if (k == 0) begin
        chk("latency", n, 2);
        chk("ocupado_busy", ocupado, 1);
        chk("estado_envia", db_estado, 2);
      end
      if (ign && k == 2) begin
        iniciar = 1; angulo = 12'($urandom); medida = 12'($urandom); medida_valida = ~v;
      end
      if (ign && k == 5) iniciar = 0;
      if (k == rst_at) begin
        #2 reset = 0;
        #1 check_idle_outputs("rst_async");
        exp_chr.delete();
        exp_evt.delete();
        @(posedge clock); #1 reset = 1;
        n = 0;
        repeat (10) begin
          @(posedge clock); #1;
          if (partida_tx) n++;
        end
        chk("no_partida_after_rst", n, 0);
        chk("estado_after_rst", db_estado, 0);
        return;
      end
      if (k == stall_at) begin
        n = 0;
        do begin
          @(posedge clock); #1;
          n++;
        end while (!erro && n < 40);
        chk("erro_delay", n, 17);
        stalled = 1;
        break;
      end
      j = tie ? 15 : dly >= 0 ? dly : int'($urandom_range(6, 0));
      pronto_tx = ign;
      @(posedge clock); #1 pronto_tx = 0;
      repeat (j) @(posedge clock);
      #1 pronto_tx = 1;
      @(posedge clock); #1 pronto_tx = 0;
    end
    if (!stalled) begin
      n = 0;
      do begin
        @(posedge clock); #1;
        n++;
      end while (!fim_frame && n < 10);
      chk("fim_seen", fim_frame, 1);
    end
    @(posedge clock); #1;
    chk("ocupado_drop", ocupado, 0);
    chk("estado_idle", db_estado, 0);
    chk("chars_left", exp_chr.size(), 0);
    chk("events_left", exp_evt.size(), 0);
    iniciar = 0;
  endtask

  function automatic logic [11:0] rnd_digits();
    return {4'($urandom_range(11, 0)), 4'($urandom_range(11, 0)), 4'($urandom_range(11, 0))};
  endfunction

  initial begin
    #1 check_idle_outputs("reset");
    repeat (3) @(posedge clock);
    #1 reset = 1;
    repeat (3) @(posedge clock);
    #1 chk("idle_no_start", {partida_tx, ocupado}, 0);
    run_frame(12'h045, 12'h123, 1, 3, -1, 0, 0, -1);
    run_frame(12'h180, 12'($urandom), 0, -1, -1, 0, 0, -1);
    run_frame(12'h0A9, 12'h123, 1, -1, -1, 1, 0, -1);
    run_frame(12'h271, 12'h999, 1, -1, 2, 0, 0, -1);
    run_frame(12'h333, 12'h456, 1, -1, -1, 0, 0, 5);
    run_frame(12'h512, 12'h078, 1, -1, -1, 0, 1, -1);
    for (int i = 0; i < 6; i++)
      run_frame(rnd_digits(), rnd_digits(), 1'($urandom_range(1, 0)), -1, -1, 0, 0, -1);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
